// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: loads a CLB configuration shift chain from a host word stream.
// Words arrive over a valid/ready handshake and are sent LSB-first on shift_i.
// shift_clk is a divided clock with exactly CHAIN_LEN rising edges per load.
// Optional feature macro: CFG_VERIFY_EN.
//   When it is defined, a second pass of CHAIN_LEN shifts re-drives the loaded
//   bits from a shadow copy. During that pass shift_o is compared with the shadow
//   copy, and any mismatch sets the sticky err flag.
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 36,
    parameter int WORD_W    = 8,
    parameter int CLK_DIV   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              shift_clk,
    output logic              shift_i,
    input  logic              shift_o
);

    localparam int BCW = $clog2(CHAIN_LEN + 1);
    localparam int WLW = $clog2(WORD_W + 1);
    localparam int DCW = $clog2(CLK_DIV + 1);

    localparam logic [BCW-1:0] LAST_BIT = BCW'(CHAIN_LEN - 1);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
    localparam logic [WLW-1:0] WL_ONE   = WLW'(1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);
    localparam logic [DCW-1:0] DIV_ONE  = DCW'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SHIFT_LO  = 3'd2,
        ST_SHIFT_HI  = 3'd3,
`ifdef CFG_VERIFY_EN
        ST_VERIFY_LO = 3'd4,
        ST_VERIFY_HI = 3'd5,
`endif
        ST_DONE      = 3'd6
    } state_t;

    state_t            state_q;
    logic [BCW-1:0]    bit_cnt_q;
    logic [WLW-1:0]    word_left_q;
    logic [DCW-1:0]    div_cnt_q;
    logic [WORD_W-1:0] shifter_q;
    logic [WORD_W-1:0] shifter_nxt_s;
    logic [WLW-1:0]    load_len_s;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              shift_clk_q;
    logic              shift_i_q;

`ifdef CFG_VERIFY_EN
    logic [CHAIN_LEN-1:0] shadow_q;
    logic [CHAIN_LEN-1:0] shadow_d;
    logic [CHAIN_LEN-1:0] shadow_top_s;
    logic                 shadow_in_s;
`else
    logic                 unused_shift_o_s;
    assign unused_shift_o_s = shift_o;
`endif

    assign cfg_ready     = (state_q == ST_LOAD);
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign shift_clk     = shift_clk_q;
    assign shift_i       = shift_i_q;
    assign shifter_nxt_s = shifter_q >> 1;

    // Bits still owed by the next word: a full word, or only what is left of the chain.
    always_comb begin
        load_len_s = WLW'(WORD_W);
        if ((CHAIN_LEN - int'(bit_cnt_q)) < WORD_W) begin
            load_len_s = WLW'(CHAIN_LEN - int'(bit_cnt_q));
        end else begin
            load_len_s = WLW'(WORD_W);
        end
    end

`ifdef CFG_VERIFY_EN
    // Shadow shifts toward bit 0. The load pass feeds in fresh bits; the verify pass rotates.
    always_comb begin
        shadow_top_s = '0;
        if (state_q == ST_VERIFY_HI) begin
            shadow_in_s = shadow_q[0];
        end else begin
            shadow_in_s = shifter_q[0];
        end
        shadow_top_s[CHAIN_LEN-1] = shadow_in_s;
        shadow_d = (shadow_q >> 1) | shadow_top_s;
    end
`endif

    // Sequencer FSM with registered shift_clk, shift_i, busy, done and err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            word_left_q <= '0;
            div_cnt_q   <= '0;
            shifter_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            shift_clk_q <= 1'b0;
            shift_i_q   <= 1'b0;
`ifdef CFG_VERIFY_EN
            shadow_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    shift_clk_q <= 1'b0;
                    shift_i_q   <= 1'b0;
                    if (start) begin
                        state_q   <= ST_LOAD;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        err_q     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // shift_clk is already low here, so waiting adds no edges.
                    if (cfg_valid) begin
                        shifter_q   <= cfg_data;
                        word_left_q <= load_len_s;
                        shift_i_q   <= cfg_data[0];
                        div_cnt_q   <= '0;
                        state_q     <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q   <= '0;
                        shift_clk_q <= 1'b1;
                        state_q     <= ST_SHIFT_HI;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_ONE;
                    end
                end
                ST_SHIFT_HI: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q   <= '0;
                        shift_clk_q <= 1'b0;
                        shifter_q   <= shifter_nxt_s;
                        word_left_q <= word_left_q - WL_ONE;
`ifdef CFG_VERIFY_EN
                        shadow_q    <= shadow_d;
`endif
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef CFG_VERIFY_EN
                            bit_cnt_q <= '0;
                            shift_i_q <= shadow_d[0];
                            state_q   <= ST_VERIFY_LO;
`else
                            bit_cnt_q <= bit_cnt_q + BIT_ONE;
                            shift_i_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_ONE;
                            if (word_left_q == WL_ONE) begin
                                state_q <= ST_LOAD;
                            end else begin
                                shift_i_q <= shifter_nxt_s[0];
                                state_q   <= ST_SHIFT_LO;
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_ONE;
                    end
                end
`ifdef CFG_VERIFY_EN
                ST_VERIFY_LO: begin
                    if (div_cnt_q == DIV_LAST) begin
                        // The chain tail now presents the bit that was shifted in CHAIN_LEN edges earlier.
                        if (shift_o != shadow_q[0]) begin
                            err_q <= 1'b1;
                        end
                        div_cnt_q   <= '0;
                        shift_clk_q <= 1'b1;
                        state_q     <= ST_VERIFY_HI;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_ONE;
                    end
                end
                ST_VERIFY_HI: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q   <= '0;
                        shift_clk_q <= 1'b0;
                        shadow_q    <= shadow_d;
                        if (bit_cnt_q == LAST_BIT) begin
                            shift_i_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_ONE;
                            shift_i_q <= shadow_d[0];
                            state_q   <= ST_VERIFY_LO;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_ONE;
                    end
                end
`endif
                ST_DONE: begin
                    shift_clk_q <= 1'b0;
                    shift_i_q   <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    shift_clk_q <= 1'b0;
                    shift_i_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Testbench for cfg_chain_loader.
// The bench models the external chain as a plain shift register clocked by shift_clk.
// Expected chain contents come from the host words: chain bit j is stream bit j.
module tb_cfg_chain_loader;

    localparam int CL = 36;
    localparam int WW = 8;
    localparam int CD = 2;
    localparam int NW = (CL + WW - 1) / WW;
`ifdef CFG_VERIFY_EN
    localparam int VMUL = 2;
`else
    localparam int VMUL = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [WW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic          shift_clk;
    logic          shift_i;
    logic          shift_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [NW*WW-1:0] words;
        int               gap;
        int               start_mid;
        int               inv_bit;
        logic [CL-1:0]    exp_chain;
        logic             exp_err;
    } vec_t;

    vec_t tbl[9];

    cfg_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CLK_DIV(CD)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_data (cfg_data),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .shift_clk(shift_clk),
        .shift_i  (shift_i),
        .shift_o  (shift_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete load. The host drives words, the chain model follows shift_clk,
    // and every result is then compared with the record.
    task automatic run_load(input int idx, input vec_t v);
        int            rises, dones, busy_cyc, clk_bad, widx, gapcnt, post;
        logic          prev_sc, seen_done, err_at_done, busy_at_done;
        logic [CL-1:0] chain_m;
        rises = 0; dones = 0; busy_cyc = 0; clk_bad = 0; widx = 0; gapcnt = 0; post = 0;
        prev_sc = 1'b0; seen_done = 1'b0; err_at_done = 1'b0; busy_at_done = 1'b1;
        chain_m = '0;
        @(negedge clk);
        start = 1'b1;
        cfg_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d err_clear_on_start", idx), {63'd0, err}, 64'd0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (busy) busy_cyc++;
            if (done) begin
                dones++;
                err_at_done  = err;
                busy_at_done = busy;
            end
            if (shift_clk && !prev_sc) begin
                rises++;
                chain_m = {shift_i, chain_m[CL-1:1]};
            end
            prev_sc = shift_clk;
            if (cfg_ready && shift_clk) clk_bad++;
            shift_o = chain_m[0] ^ ((v.inv_bit >= 0) && (rises >= CL) && ((rises - CL) == v.inv_bit));
            start = (cyc == v.start_mid);
            if (widx < NW && gapcnt >= v.gap) begin
                cfg_valid = 1'b1;
                cfg_data  = v.words[widx*WW +: WW];
                if (cfg_ready) begin
                    widx++;
                    gapcnt = 0;
                end
            end else begin
                cfg_valid = 1'b0;
                if (cfg_ready) gapcnt++;
            end
            if (seen_done) post++;
            if (done) seen_done = 1'b1;
            if (post == 3) break;
            @(negedge clk);
        end
        start = 1'b0;
        cfg_valid = 1'b0;
        check($sformatf("v%0d done_within_budget", idx), {63'd0, seen_done}, 64'd1);
        check($sformatf("v%0d shift_clk_rises", idx), 64'(rises), 64'(CL * VMUL));
        check($sformatf("v%0d chain_contents", idx), 64'(chain_m), 64'(v.exp_chain));
        check($sformatf("v%0d done_pulses", idx), 64'(dones), 64'd1);
        check($sformatf("v%0d busy_low_with_done", idx), {63'd0, busy_at_done}, 64'd0);
        check($sformatf("v%0d busy_cycles", idx), 64'(busy_cyc),
              64'(CL * 2 * CD * VMUL + NW * (1 + v.gap)));
        check($sformatf("v%0d clk_low_in_load", idx), 64'(clk_bad), 64'd0);
        check($sformatf("v%0d err_at_done", idx), {63'd0, err_at_done}, {63'd0, v.exp_err});
        check($sformatf("v%0d err_sticky", idx), {63'd0, err}, {63'd0, v.exp_err});
        check($sformatf("v%0d idle_after", idx), {61'd0, busy, cfg_ready, shift_clk}, 64'd0);
    endtask

    initial begin
        logic [NW*WW-1:0] rw;
        logic             got_hi;
        rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; shift_o = 1'b0;

        // Records: basic, backpressure, last-word mask, mid-load start, zero reload,
        // verify fault injection, zero reload, two random loads.
        tbl[0] = '{40'h09_A5_C3_0F_1E, 0, -1, -1, 36'h9A5C30F1E, 1'b0};
        tbl[1] = '{40'h09_A5_C3_0F_1E, 10, -1, -1, 36'h9A5C30F1E, 1'b0};
        tbl[2] = '{40'hF9_A5_C3_0F_1E, 0, -1, -1, 36'h9A5C30F1E, 1'b0};
        tbl[3] = '{40'h09_A5_C3_0F_1E, 0, 40, -1, 36'h9A5C30F1E, 1'b0};
        tbl[4] = '{40'h00_00_00_00_00, 0, -1, -1, 36'h000000000, 1'b0};
        tbl[5] = '{40'h09_A5_C3_0F_1E, 0, -1, 7, 36'h9A5C30F1E, (VMUL == 2)};
        tbl[6] = '{40'h00_00_00_00_00, 0, -1, -1, 36'h000000000, 1'b0};
        for (int r = 7; r < 9; r++) begin
            rw = {$urandom, $urandom};
            tbl[r] = '{rw, int'($urandom_range(3, 0)), -1, -1, rw[CL-1:0], 1'b0};
        end

        repeat (3) @(negedge clk);
        check("reset_outputs", {58'd0, shift_clk, shift_i, cfg_ready, busy, done, err}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_start", {62'd0, busy, cfg_ready}, 64'd0);

        // Reset asserted mid-load while shift_clk is high and shift_i carries a one.
        start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        got_hi = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (shift_clk) begin
                got_hi = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("pre_reset_shifting", {61'd0, got_hi, busy, shift_i}, 64'd7);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", {58'd0, shift_clk, shift_i, cfg_ready, busy, done, err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {61'd0, busy, cfg_ready, shift_clk}, 64'd0);

        for (int r = 0; r < 9; r++) begin
            run_load(r, tbl[r]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
Sequencer that loads a CLB configuration shift chain from a host word stream. Accepts WORD_W-bit words over a valid/ready handshake, serializes them LSB-first onto shift_i, and generates a divided shift_clk with exactly CHAIN_LEN rising edges per load. Sits between the host/bitstream source and the shift_i/shift_clk/shift_o pins of one CLB or a daisy-chain of CLBs.

Parameters:
CHAIN_LEN, 36, total chain bits (CLB_CONFIG_LEN + 2*LUT_CONFIG_LEN for one CLB); must be >= 1
WORD_W, 8, host word width; must be >= 1
CLK_DIV, 2, clk cycles per shift_clk phase (low phase and high phase each CLK_DIV cycles); must be >= 1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse begins a load; ignored while busy
cfg_data  input  WORD_W  configuration word, bit 0 shifted first
cfg_valid  input  1  cfg_data valid
cfg_ready  output  1  loader accepts a word this cycle
busy  output  1  load in progress
done  output  1  one-cycle pulse at load completion
err  output  1  verify mismatch flag (see Optional Feature); sticky until next start
shift_clk  output  1  generated chain clock
shift_i  output  1  serial data to chain
shift_o  input  1  serial data from chain tail

Behaviour:
- Reset (async): state IDLE; shift_clk=0, shift_i=0, cfg_ready=0, busy=0, done=0, err=0, counters 0. Reset mid-load forces shift_clk low immediately; chain contents undefined; host must restart.
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, (VERIFY_LO, VERIFY_HI if enabled), DONE.
- IDLE: shift_clk=0, shift_i=0. start=1 -> LOAD next cycle, busy=1, bit_cnt=0, err=0.
- LOAD: cfg_ready=1 (combinational from state). cfg_valid&cfg_ready -> latch word into shifter, word_left = min(WORD_W, CHAIN_LEN-bit_cnt), -> SHIFT_LO. cfg_ready=0 in every other state.
- SHIFT_LO: shift_clk=0, shift_i=shifter[0] (registered, stable for the whole low and high phase); after CLK_DIV cycles -> SHIFT_HI.
- SHIFT_HI: shift_clk=1 for CLK_DIV cycles; on exit bit_cnt++, word_left--, shifter>>=1. Then: bit_cnt==CHAIN_LEN -> DONE (or VERIFY_LO); else word_left==0 -> LOAD; else SHIFT_LO.
- One bit costs exactly 2*CLK_DIV cycles; shift_clk stays low while waiting in LOAD (backpressure adds no edges).
- Word packing: word k carries chain bits k*WORD_W..; ceil(CHAIN_LEN/WORD_W) words per load; unused upper bits of the last word ignored.
- DONE: done=1 for one cycle, busy=0 at the same edge, shift_clk=0, -> IDLE. start in DONE ignored.
- start while busy: ignored, no effect on counters.
- Exactly CHAIN_LEN shift_clk rising edges per load (2*CHAIN_LEN with verify).

Optional Feature:
Macro CFG_VERIFY_EN. Defined: each shifted bit also stored in a CHAIN_LEN-bit shadow register; after bit CHAIN_LEN, VERIFY_LO/VERIFY_HI perform CHAIN_LEN more shifts driving shift_i=shadow[i] (chain ends with identical contents) and, in the last clk cycle of each VERIFY_LO, compare shift_o with shadow[i]; any mismatch sets err=1 (sticky); err valid when done pulses. No host words consumed in verify. Undefined: no shadow, no verify states, err tied 0, load ends after CHAIN_LEN edges.

Test Plan:
- Reset: assert rst mid-operation -> shift_clk, shift_i, cfg_ready, busy, done, err all 0 same cycle; IDLE after release.
- Basic load (CHAIN_LEN=36, WORD_W=8, CLK_DIV=2): start, words 0x1E,0x0F,0xC3,0xA5,0x09 always valid -> exactly 36 shift_clk rises, bench 36-bit shift model holds 36'h9A5C30F1E, done one pulse, busy low after; 144 shift cycles plus 5 LOAD cycles.
- Backpressure: same words with 10-cycle cfg_valid gaps -> shift_clk low during gaps, still 36 rises, same result.
- Last-word mask: 5th word 0xF9 -> chain 36'h9A5C30F1E, upper nibble ignored, no 37th edge.
- start pulsed mid-load -> ignored, still 36 edges; then start after done -> second load of all-zero words clears chain to 0.
- CFG_VERIFY_EN: basic load -> 72 edges, chain 36'h9A5C30F1E, err=0; bench inverts shift_o at verify bit 7 -> err=1 at done and stays 1 until next start.
